frv_rngif_buf: RTL and testbench

- Parametrised next-generation interface between the execute stage and the external random number generator.
- Adds a prefetch FIFO of random samples, filled autonomously by a refill engine while the RNG reports healthy, so `samp` normally completes in zero wait cycles.
- `test` and `seed` ops, and `samp` on an empty buffer, go directly to the RNG via a single-outstanding request/response state machine.
- Sits beside the ALU/LSU in execute; the writeback mux consumes `result`/`ready`.

---
 rtl/frv_rngif_buf_pkg.sv | 37 +++
 rtl/frv_rngif_fifo.sv | 54 +++++
 rtl/frv_rngif_buf.sv | 165 ++++++++++++++++
 tb/tb_frv_rngif_buf.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_rngif_buf_pkg.sv
// Shared definitions for the execute-stage RNG interface:
// status codes, op bit positions and FSM encodings.
package frv_rngif_buf_pkg;

    localparam logic [2:0] RNG_IF_INIT_NO_INIT   = 3'b000;
    localparam logic [2:0] RNG_IF_INIT_HEALTHY   = 3'b001;
    localparam logic [2:0] RNG_IF_INIT_UNHEALTHY = 3'b010;

    localparam int RNG_OP_SEED = 0;
    localparam int RNG_OP_SAMP = 1;
    localparam int RNG_OP_TEST = 2;

    typedef enum logic [1:0] {
        RNGIF_IDLE = 2'd0,
        RNGIF_REQ  = 2'd1,
        RNGIF_RSP  = 2'd2
    } rngif_state_t;

    typedef enum logic {
        OWN_CPU    = 1'b0,
        OWN_REFILL = 1'b1
    } rngif_owner_t;

    function automatic logic [2:0] rng_op(
        input logic test,
        input logic samp,
        input logic seed
    );
        logic [2:0] op;
        op              = '0;
        op[RNG_OP_TEST] = test;
        op[RNG_OP_SAMP] = samp;
        op[RNG_OP_SEED] = seed;
        return op;
    endfunction

endpackage

// File: rtl/frv_rngif_fifo.sv
// Prefetch FIFO of random samples; clear wins over push,
// and a pop lets a push proceed while full.
module frv_rngif_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   wptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge g_clk) begin
        if (do_push && !clear) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/frv_rngif_buf.sv
// Execute-stage RNG interface with a prefetch buffer kept full
// by a refill engine; direct ops share one outstanding slot.
module frv_rngif_buf
    import frv_rngif_buf_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int REFILL_EN = 1
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   flush,
    input  logic                   pipeline_progress,
    input  logic                   valid,
    input  logic [XLEN-1:0]        rs1,
    input  logic                   uop_test,
    input  logic                   uop_seed,
    input  logic                   uop_samp,
    output logic [XLEN-1:0]        result,
    output logic                   ready,
    output logic                   rng_req_valid,
    output logic [2:0]             rng_req_op,
    output logic [XLEN-1:0]        rng_req_data,
    input  logic                   rng_req_ready,
    input  logic                   rng_rsp_valid,
    input  logic [2:0]             rng_rsp_status,
    input  logic [XLEN-1:0]        rng_rsp_data,
    output logic                   rng_rsp_ready,
    output logic [$clog2(DEPTH):0] buf_count
);

    rngif_state_t    state, state_d;
    rngif_owner_t    owner, owner_d;
    logic            discard, discard_d;
    logic            healthy, healthy_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] data_q, data_d;

    logic [XLEN-1:0] head;
    logic            full;
    logic            empty;
    logic [2:0]      cpu_op;
    logic            cpu_busy;
    logic            hit;
    logic            direct;
    logic            refill_go;
    logic            drop;
    logic            rsp_fire;
    logic            healthy_now;
    logic            cpu_rsp;
    logic            push;
    logic            pop;
    logic            clear;

    assign cpu_op      = rng_op(uop_test, uop_samp, uop_seed);
    assign cpu_busy    = (state != RNGIF_IDLE) && (owner == OWN_CPU);
    assign hit         = valid && uop_samp && !empty && !cpu_busy;
    assign direct      = valid && (|cpu_op) && !hit && !flush;
    assign refill_go   = (REFILL_EN != 0) && healthy && !full && !direct;
    assign drop        = discard || flush;
    assign healthy_now = (rng_rsp_status == RNG_IF_INIT_HEALTHY);
    assign rsp_fire    = (state == RNGIF_RSP) && rng_rsp_valid && rng_rsp_ready;
    assign cpu_rsp     = (state == RNGIF_RSP) && (owner == OWN_CPU) &&
                         !drop && rng_rsp_valid;

    assign push  = (state == RNGIF_RSP) && (owner == OWN_REFILL) &&
                   rng_rsp_valid && healthy_now;
    assign pop   = hit && pipeline_progress && !flush;
    // Seed acceptance and bad health both invalidate buffered samples.
    assign clear = (rsp_fire && !healthy_now) ||
                   ((state == RNGIF_REQ) && (owner == OWN_CPU) &&
                    op_q[RNG_OP_SEED] && rng_req_ready);

    assign rng_req_valid = (state == RNGIF_REQ);
    assign rng_req_op    = (state == RNGIF_IDLE) ? cpu_op : op_q;
    assign rng_req_data  = (state == RNGIF_IDLE) ? rs1 : data_q;
    assign rng_rsp_ready = (state == RNGIF_RSP) &&
                           ((owner == OWN_REFILL) || drop || pipeline_progress);
    assign ready         = hit || cpu_rsp;

    always_comb begin
        result = '0;
        unique case (1'b1)
            hit: result = head;
            cpu_rsp: begin
                if (op_q[RNG_OP_SAMP])      result = rng_rsp_data;
                else if (op_q[RNG_OP_TEST]) result = XLEN'(healthy_now);
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        state_d   = state;
        owner_d   = owner;
        discard_d = discard;
        healthy_d = healthy;
        op_d      = op_q;
        data_d    = data_q;
        if (rsp_fire) healthy_d = healthy_now;
        unique case (state)
            RNGIF_IDLE: begin
                discard_d = 1'b0;
                if (direct) begin
                    state_d = RNGIF_REQ;
                    owner_d = OWN_CPU;
                    op_d    = cpu_op;
                    data_d  = rs1;
                end else if (refill_go) begin
                    state_d = RNGIF_REQ;
                    owner_d = OWN_REFILL;
                    op_d    = rng_op(1'b0, 1'b1, 1'b0);
                    data_d  = '0;
                end
            end
            RNGIF_REQ: begin
                if (flush && (owner == OWN_CPU)) discard_d = 1'b1;
                if (rng_req_ready) state_d = RNGIF_RSP;
            end
            RNGIF_RSP: begin
                if (flush && (owner == OWN_CPU)) discard_d = 1'b1;
                if (rsp_fire) begin
                    state_d   = RNGIF_IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = RNGIF_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state   <= RNGIF_IDLE;
            owner   <= OWN_CPU;
            discard <= 1'b0;
            healthy <= 1'b0;
            op_q    <= '0;
            data_q  <= '0;
        end else begin
            state   <= state_d;
            owner   <= owner_d;
            discard <= discard_d;
            healthy <= healthy_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    frv_rngif_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push     (push),
        .pop      (pop),
        .clear    (clear),
        .wdata    (rng_rsp_data),
        .head     (head),
        .count    (buf_count),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_frv_rngif_buf.sv
// Bench for frv_rngif_buf: behavioural RNG responder plus a
// result scoreboard filled by the CPU-side driver.
module tb_frv_rngif_buf;
    import frv_rngif_buf_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [2:0] OP_TEST = 3'b100;
    localparam logic [2:0] OP_SAMP = 3'b010;
    localparam logic [2:0] OP_SEED = 3'b001;

    logic            g_clk;
    logic            g_resetn;
    logic            flush;
    logic            pipeline_progress;
    logic            valid;
    logic [XLEN-1:0] rs1;
    logic            uop_test;
    logic            uop_seed;
    logic            uop_samp;
    logic [XLEN-1:0] result;
    logic            ready;
    logic            rng_req_valid;
    logic [2:0]      rng_req_op;
    logic [XLEN-1:0] rng_req_data;
    logic            rng_req_ready;
    logic            rng_rsp_valid;
    logic [2:0]      rng_rsp_status;
    logic [XLEN-1:0] rng_rsp_data;
    logic            rng_rsp_ready;
    logic [2:0]      buf_count;

    int n_vec   = 0;
    int n_err   = 0;
    int retired = 0;
    int n_req   = 0;
    int n_rsp   = 0;
    int rng_lat = 1;

    logic [2:0]  rng_status;
    logic [31:0] rng_next;
    logic [2:0]  last_op;
    logic [31:0] last_data;
    logic [31:0] exp_q[$];

    frv_rngif_buf #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .REFILL_EN (1)
    ) dut (
        .g_clk             (g_clk),
        .g_resetn          (g_resetn),
        .flush             (flush),
        .pipeline_progress (pipeline_progress),
        .valid             (valid),
        .rs1               (rs1),
        .uop_test          (uop_test),
        .uop_seed          (uop_seed),
        .uop_samp          (uop_samp),
        .result            (result),
        .ready             (ready),
        .rng_req_valid     (rng_req_valid),
        .rng_req_op        (rng_req_op),
        .rng_req_data      (rng_req_data),
        .rng_req_ready     (rng_req_ready),
        .rng_rsp_valid     (rng_rsp_valid),
        .rng_rsp_status    (rng_rsp_status),
        .rng_rsp_data      (rng_rsp_data),
        .rng_rsp_ready     (rng_rsp_ready),
        .buf_count         (buf_count)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // RNG model: always ready, responds rng_lat cycles after acceptance.
    initial begin
        logic       rq;
        logic       rs;
        logic       pend;
        int         wcnt;
        logic [2:0] qop;
        logic [2:0] pop_op;
        logic [31:0] qdat;
        rng_req_ready  = 1'b1;
        rng_rsp_valid  = 1'b0;
        rng_rsp_status = RNG_IF_INIT_NO_INIT;
        rng_rsp_data   = '0;
        pend   = 1'b0;
        wcnt   = 0;
        pop_op = '0;
        forever begin
            @(posedge g_clk);
            rq   = rng_req_valid && rng_req_ready;
            rs   = rng_rsp_valid && rng_rsp_ready;
            qop  = rng_req_op;
            qdat = rng_req_data;
            #1;
            if (!g_resetn) begin
                pend          = 1'b0;
                rng_rsp_valid = 1'b0;
            end else begin
                if (rs) begin
                    rng_rsp_valid = 1'b0;
                    n_rsp++;
                end
                if (rq) begin
                    pend      = 1'b1;
                    wcnt      = rng_lat;
                    pop_op    = qop;
                    last_op   = qop;
                    last_data = qdat;
                    n_req++;
                end
                if (pend && !rng_rsp_valid) begin
                    if (wcnt == 0) begin
                        rng_rsp_valid  = 1'b1;
                        rng_rsp_status = rng_status;
                        rng_rsp_data   = pop_op[RNG_OP_SAMP] ? rng_next : '0;
                        if (pop_op[RNG_OP_SAMP]) rng_next = rng_next + 1;
                        pend = 1'b0;
                    end else begin
                        wcnt--;
                    end
                end
            end
        end
    end

    // Retirement monitor: a result is consumed when ready meets progress.
    always @(posedge g_clk) begin
        if (g_resetn && ready && pipeline_progress) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check("result", result, exp_q.pop_front());
            end
            retired++;
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [31:0] d,
                         input logic [31:0] want, output int cyc);
        int r0;
        r0 = retired;
        exp_q.push_back(want);
        valid    = 1'b1;
        uop_test = op[2];
        uop_samp = op[1];
        uop_seed = op[0];
        rs1      = d;
        cyc      = 0;
        do begin
            @(posedge g_clk);
            #1;
            cyc++;
        end while (retired == r0 && cyc < 200);
        check("op_done", 32'(retired - r0), 32'd1);
        valid    = 1'b0;
        uop_test = 1'b0;
        uop_samp = 1'b0;
        uop_seed = 1'b0;
    endtask

    task automatic wait_count(input int n, input string tag);
        int k;
        k = 0;
        while (32'(buf_count) != n && k < 300) begin
            @(posedge g_clk);
            #1;
            k++;
        end
        check(tag, 32'(buf_count), n);
    endtask

    initial begin
        int   cyc;
        int   r;
        int   r2;
        int   k;
        logic saw;
        flush             = 1'b0;
        pipeline_progress = 1'b1;
        valid             = 1'b0;
        rs1               = '0;
        uop_test          = 1'b0;
        uop_seed          = 1'b0;
        uop_samp          = 1'b0;
        rng_status        = RNG_IF_INIT_HEALTHY;
        rng_next          = 32'hA0;
        rng_lat           = 1;
        g_resetn          = 1'b1;
        #1 g_resetn = 1'b0;
        #2;
        check("rst_ready", 32'(ready), 0);
        check("rst_req_valid", 32'(rng_req_valid), 0);
        check("rst_rsp_ready", 32'(rng_rsp_ready), 0);
        check("rst_count", 32'(buf_count), 0);
        repeat (2) @(posedge g_clk);
        #1 g_resetn = 1'b1;

        do_op(OP_TEST, 32'h0, 32'd1, cyc);
        check("test_lat", cyc, 4);
        wait_count(4, "fill");
        check("refill_op", 32'(last_op), 32'(OP_SAMP));
        check("refill_data", last_data, 32'h0);
        repeat (3) @(posedge g_clk);
        #1;
        check("full_no_req", 32'(rng_req_valid), 0);

        for (int i = 0; i < 3; i++) begin
            do_op(OP_SAMP, 32'h0, 32'hA0 + i, cyc);
            check("hit_lat", cyc, 1);
        end
        wait_count(4, "refill_again");

        rng_status = RNG_IF_INIT_UNHEALTHY;
        do_op(OP_SAMP, 32'h0, 32'hA3, cyc);
        check("hit_lat", cyc, 1);
        wait_count(0, "unhealthy_clear");
        r = n_req;
        repeat (10) @(posedge g_clk);
        #1;
        check("refill_stopped", 32'(n_req - r), 0);

        rng_status = RNG_IF_INIT_HEALTHY;
        rng_next   = 32'h55;
        do_op(OP_SAMP, 32'h0, 32'h55, cyc);
        check("direct_samp_lat", cyc, 4);

        wait_count(2, "pre_seed");
        rng_next = 32'h77;
        do_op(OP_SEED, 32'hDEADBEEF, 32'h0, cyc);
        check("seed_count", 32'(buf_count), 0);
        check("seed_op", 32'(last_op), 32'(OP_SEED));
        check("seed_data", last_data, 32'hDEADBEEF);
        wait_count(1, "post_seed_fill");
        do_op(OP_SAMP, 32'h0, 32'h77, cyc);
        check("hit_lat", cyc, 1);

        rng_status = RNG_IF_INIT_UNHEALTHY;
        do_op(OP_TEST, 32'h0, 32'h0, cyc);
        check("unh_count", 32'(buf_count), 0);

        pipeline_progress = 1'b0;
        rng_lat  = 3;
        rng_next = 32'h1234;
        r        = n_req;
        r2       = n_rsp;
        saw      = 1'b0;
        valid    = 1'b1;
        uop_samp = 1'b1;
        k        = 0;
        while (n_req == r && k < 50) begin
            @(posedge g_clk);
            #2;
            saw = saw | ready;
            k++;
        end
        flush    = 1'b1;
        valid    = 1'b0;
        uop_samp = 1'b0;
        @(posedge g_clk);
        #2;
        saw   = saw | ready;
        flush = 1'b0;
        k     = 0;
        while (n_rsp == r2 && k < 50) begin
            @(posedge g_clk);
            #2;
            saw = saw | ready;
            k++;
        end
        check("flush_consumed", 32'(n_rsp - r2), 1);
        check("flush_no_ready", 32'(saw), 0);
        pipeline_progress = 1'b1;

        rng_status = RNG_IF_INIT_HEALTHY;
        rng_lat    = 1;
        do_op(OP_TEST, 32'h0, 32'd1, cyc);
        wait_count(4, "refill_resume");

        rng_lat  = 4;
        valid    = 1'b1;
        uop_test = 1'b1;
        k        = 0;
        while (!rng_rsp_valid && k < 50) begin
            @(posedge g_clk);
            #2;
            k++;
        end
        check("pre_rst_ready", 32'(ready), 1);
        check("pre_rst_count", 32'(buf_count), 4);
        #1 g_resetn = 1'b0;
        #1;
        check("arst_req_valid", 32'(rng_req_valid), 0);
        check("arst_rsp_ready", 32'(rng_rsp_ready), 0);
        check("arst_ready", 32'(ready), 0);
        check("arst_count", 32'(buf_count), 0);
        valid    = 1'b0;
        uop_test = 1'b0;
        repeat (2) @(posedge g_clk);
        #1 g_resetn = 1'b1;
        repeat (2) @(posedge g_clk);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
